// File: rtl/conc_sched_if.sv
// Lane-to-concatenator bus for conc_sched: three code lanes (Y, Cb, Cr) in,
// one serialised code stream out.
interface conc_sched_if;
  logic [17:0] lane_len;
  logic [71:0] lane_bin;
  logic [2:0]  lane_eob;
  logic [2:0]  lane_valid;
  logic [2:0]  lane_ready;
  logic [5:0]  out_len;
  logic [23:0] out_bin;
  logic        out_valid;
  logic        out_eoi;

  modport master (
    output lane_len, lane_bin, lane_eob, lane_valid,
    input  lane_ready, out_len, out_bin, out_valid, out_eoi
  );

  modport slave (
    input  lane_len, lane_bin, lane_eob, lane_valid,
    output lane_ready, out_len, out_bin, out_valid, out_eoi
  );
endinterface

// File: rtl/conc_sched.sv
// MCU-ordered code scheduler: drains Y_BLKS luma blocks, then Cb, then Cr per
// MCU into a single code stream, flags end of image and flushes before done.
module conc_sched #(
  parameter int Y_BLKS = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] mcu_total,
  conc_sched_if.slave      lanes,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LUMA  = 3'd1;
  localparam logic [2:0] CB    = 3'd2;
  localparam logic [2:0] CR    = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;

  logic [2:0]       state;
  logic [2:0]       blk_cnt;
  logic [CNT_W-1:0] mcu_cnt;
  logic [CNT_W-1:0] mcu_total_q;
  logic [CNT_W-1:0] mcu_nxt;
  logic             flush_cnt;
  logic [5:0]       sel_len;
  logic [23:0]      sel_bin;
  logic             sel_eob;
  logic             acc;
  logic             len_ok;
  logic             mcu_last;

  // Ready depends on state alone, so the lane mux below never loops back
  // through lane_valid.
  always_comb begin
    lanes.lane_ready = '0;
    sel_len          = '0;
    sel_bin          = '0;
    sel_eob          = 1'b0;
    case (state)
      LUMA: begin
        lanes.lane_ready = 3'b001;
        sel_len          = lanes.lane_len[5:0];
        sel_bin          = lanes.lane_bin[23:0];
        sel_eob          = lanes.lane_eob[0];
      end
      CB: begin
        lanes.lane_ready = 3'b010;
        sel_len          = lanes.lane_len[11:6];
        sel_bin          = lanes.lane_bin[47:24];
        sel_eob          = lanes.lane_eob[1];
      end
      CR: begin
        lanes.lane_ready = 3'b100;
        sel_len          = lanes.lane_len[17:12];
        sel_bin          = lanes.lane_bin[71:48];
        sel_eob          = lanes.lane_eob[2];
      end
      default: ;
    endcase
  end

  assign acc      = |(lanes.lane_valid & lanes.lane_ready);
  assign len_ok   = (sel_len <= 6'd24);
  assign mcu_nxt  = mcu_cnt + CNT_W'(1);
  assign mcu_last = (mcu_nxt == mcu_total_q);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      blk_cnt         <= '0;
      mcu_cnt         <= '0;
      mcu_total_q     <= '0;
      flush_cnt       <= 1'b0;
      lanes.out_len   <= '0;
      lanes.out_bin   <= '0;
      lanes.out_valid <= 1'b0;
      lanes.out_eoi   <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      lanes.out_valid <= 1'b0;
      lanes.out_eoi   <= 1'b0;
      done            <= 1'b0;

      // Oversized codes are dropped from the stream but still sequence below.
      if (acc) begin
        if (len_ok) begin
          lanes.out_len   <= sel_len;
          lanes.out_bin   <= sel_bin;
          lanes.out_valid <= 1'b1;
          lanes.out_eoi   <= (state == CR) && sel_eob && mcu_last;
        end else begin
          err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (mcu_total != '0) begin
              state       <= LUMA;
              mcu_total_q <= mcu_total;
              blk_cnt     <= '0;
              mcu_cnt     <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        LUMA: begin
          if (acc && sel_eob) begin
            if (blk_cnt == 3'(Y_BLKS - 1)) begin
              blk_cnt <= '0;
              state   <= CB;
            end else begin
              blk_cnt <= blk_cnt + 3'd1;
            end
          end
        end
        CB: begin
          if (acc && sel_eob) state <= CR;
        end
        CR: begin
          if (acc && sel_eob) begin
            mcu_cnt <= mcu_nxt;
            if (mcu_last) begin
              state     <= FLUSH;
              flush_cnt <= 1'b0;
            end else begin
              state <= LUMA;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conc_sched.sv
// Directed bench for conc_sched: per-lane code queues feed the DUT, the output
// stream is logged, and each scenario task checks its log against hand values.
module tb_conc_sched;

  typedef struct packed {
    logic [5:0]  len;
    logic [23:0] bin;
    logic        eob;
  } code_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mcu_total;
  logic        busy;
  logic        done;
  logic        err;

  conc_sched_if bus ();

  conc_sched #(.Y_BLKS(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mcu_total (mcu_total),
    .lanes     (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  code_t y_q[$];
  code_t cb_q[$];
  code_t cr_q[$];

  logic [5:0]  log_len[$];
  logic [23:0] log_bin[$];
  logic        log_eoi[$];
  int          log_cyc[$];
  int          done_cyc;
  logic        busy_at_done;
  logic        busy_seen;
  logic        err_seen;
  int          n_y_acc;
  int          y_at_chroma_ready;

  task automatic push(input int lane, input int len, input int bin, input bit eob);
    code_t c;
    c.len = 6'(len);
    c.bin = 24'(bin);
    c.eob = eob;
    if (lane == 0) y_q.push_back(c);
    else if (lane == 1) cb_q.push_back(c);
    else cr_q.push_back(c);
  endtask

  task automatic drive_lanes();
    bus.lane_valid = '0;
    bus.lane_len   = '0;
    bus.lane_bin   = '0;
    bus.lane_eob   = '0;
    if (y_q.size() != 0) begin
      bus.lane_valid[0]   = 1'b1;
      bus.lane_len[5:0]   = y_q[0].len;
      bus.lane_bin[23:0]  = y_q[0].bin;
      bus.lane_eob[0]     = y_q[0].eob;
    end
    if (cb_q.size() != 0) begin
      bus.lane_valid[1]   = 1'b1;
      bus.lane_len[11:6]  = cb_q[0].len;
      bus.lane_bin[47:24] = cb_q[0].bin;
      bus.lane_eob[1]     = cb_q[0].eob;
    end
    if (cr_q.size() != 0) begin
      bus.lane_valid[2]   = 1'b1;
      bus.lane_len[17:12] = cr_q[0].len;
      bus.lane_bin[71:48] = cr_q[0].bin;
      bus.lane_eob[2]     = cr_q[0].eob;
    end
  endtask

  task automatic apply_reset();
    y_q.delete();
    cb_q.delete();
    cr_q.delete();
    start     = 1'b0;
    mcu_total = '0;
    drive_lanes();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // total < 0 means no start on the first cycle; restart_cyc re-pulses start.
  task automatic run(input int total, input int restart_cyc, input int restart_total,
                     input int max_cyc);
    logic [2:0] acc;
    log_len.delete();
    log_bin.delete();
    log_eoi.delete();
    log_cyc.delete();
    done_cyc          = -1;
    busy_at_done      = 1'b0;
    busy_seen         = 1'b0;
    err_seen          = 1'b0;
    n_y_acc           = 0;
    y_at_chroma_ready = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c == 1 && total >= 0) begin
        start     = 1'b1;
        mcu_total = 16'(total);
      end else if (c == restart_cyc) begin
        start     = 1'b1;
        mcu_total = 16'(restart_total);
      end else begin
        start = 1'b0;
      end
      drive_lanes();
      if (bus.lane_ready[2:1] != 2'b00 && y_at_chroma_ready < 0) y_at_chroma_ready = n_y_acc;
      acc = bus.lane_valid & bus.lane_ready;
      @(posedge clk);
      #1;
      if (acc[0]) begin void'(y_q.pop_front());  n_y_acc++; end
      if (acc[1]) void'(cb_q.pop_front());
      if (acc[2]) void'(cr_q.pop_front());
      if (bus.out_valid) begin
        log_len.push_back(bus.out_len);
        log_bin.push_back(bus.out_bin);
        log_eoi.push_back(bus.out_eoi);
        log_cyc.push_back(c);
      end
      if (busy) busy_seen = 1'b1;
      if (err)  err_seen  = 1'b1;
      if (done && done_cyc < 0) begin
        done_cyc     = c;
        busy_at_done = busy;
      end
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    drive_lanes();
  endtask

  task automatic test_reset();
    apply_reset();
    bus.lane_valid = 3'b111;
    bus.lane_len   = '1;
    bus.lane_bin   = '1;
    n_tests++;
    if ({bus.out_valid, bus.out_eoi, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {bus.out_valid, bus.out_eoi, busy, done, err});
    end
    n_tests++;
    if (bus.lane_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 000", bus.lane_ready);
    end
    n_tests++;
    if ({bus.out_len, bus.out_bin} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_data: got len %0d bin %h want 0 0", bus.out_len, bus.out_bin);
    end
    drive_lanes();
  endtask

  task automatic test_basic_mcu();
    apply_reset();
    for (int i = 0; i < 4; i++) push(0, 4, 'hA, 1'b1);
    push(1, 4, 'hA, 1'b1);
    push(2, 4, 'hA, 1'b1);
    run(1, -1, 0, 40);
    n_tests++;
    if (log_len.size() != 6) begin
      n_fail++;
      $display("FAIL basic_count: got %0d codes want 6", log_len.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (log_len[i] !== 6'd4 || log_bin[i] !== 24'hA || log_eoi[i] !== (i == 5)) begin
          n_fail++;
          $display("FAIL basic_code%0d: got len %0d bin %h eoi %b want 4 00000a %b",
                   i, log_len[i], log_bin[i], log_eoi[i], (i == 5));
        end
      end
      n_tests++;
      if (log_cyc[5] - log_cyc[0] != 5) begin
        n_fail++;
        $display("FAIL basic_spacing: got %0d cycles want 5", log_cyc[5] - log_cyc[0]);
      end
      n_tests++;
      if (done_cyc - log_cyc[5] != 2) begin
        n_fail++;
        $display("FAIL basic_done_delay: got %0d want 2", done_cyc - log_cyc[5]);
      end
    end
    n_tests++;
    if (done_cyc < 0 || busy_at_done !== 1'b0 || busy_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got done_cyc %0d busy_at_done %b busy_seen %b want >=0 0 1",
               done_cyc, busy_at_done, busy_seen);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    int cb_idx;
    apply_reset();
    for (int i = 0; i < 12; i++) push(0, (i == 0) ? 0 : 5, 'h100 + i, (i % 3) == 2);
    push(1, 7, 'h200, 1'b1);
    push(2, 7, 'h300, 1'b1);
    run(1, -1, 0, 60);
    n_tests++;
    if (y_at_chroma_ready != 12) begin
      n_fail++;
      $display("FAIL b2b_chroma_ready: got after %0d Y codes want 12", y_at_chroma_ready);
    end
    cb_idx = -1;
    for (int i = 0; i < log_bin.size(); i++) if (log_bin[i] == 24'h200 && cb_idx < 0) cb_idx = i;
    n_tests++;
    if (cb_idx != 12 || log_len.size() != 14) begin
      n_fail++;
      $display("FAIL b2b_order: got cb at %0d of %0d want 12 of 14", cb_idx, log_len.size());
    end
    n_tests++;
    if (log_len.size() == 0 || log_len[0] !== 6'd0 || log_bin[0] !== 24'h100) begin
      n_fail++;
      $display("FAIL b2b_len0: got %0d codes want first len 0 bin 000100", log_len.size());
    end
    n_tests++;
    if (log_len.size() < 12 || log_bin[11] !== 24'h10b) begin
      n_fail++;
      $display("FAIL b2b_last_y: got %0d codes want 12th bin 00010b", log_len.size());
    end
  endtask

  task automatic test_zero_total();
    apply_reset();
    push(0, 4, 'h1, 1'b1);
    run(0, -1, 0, 6);
    n_tests++;
    if (done_cyc != 1) begin
      n_fail++;
      $display("FAIL zero_done: got cycle %0d want 1", done_cyc);
    end
    n_tests++;
    if (log_len.size() != 0 || busy_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_quiet: got %0d codes busy_seen %b want 0 0", log_len.size(), busy_seen);
    end
    n_tests++;
    if (bus.lane_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL zero_ready: got %b want 000", bus.lane_ready);
    end
  endtask

  task automatic test_err_len();
    apply_reset();
    push(0, 25, 'h1FFFFFF, 1'b1);
    for (int i = 0; i < 3; i++) push(0, 3, 'h5, 1'b1);
    push(1, 3, 'h6, 1'b1);
    push(2, 3, 'h7, 1'b1);
    run(1, -1, 0, 40);
    n_tests++;
    if (err_seen !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got seen %b now %b want 1 1", err_seen, err);
    end
    n_tests++;
    if (log_len.size() != 5 || done_cyc < 0) begin
      n_fail++;
      $display("FAIL err_drop: got %0d codes done_cyc %0d want 5 >=0", log_len.size(), done_cyc);
    end
    for (int i = 0; i < log_len.size(); i++) begin
      n_tests++;
      if (log_len[i] > 6'd24) begin
        n_fail++;
        $display("FAIL err_fwd%0d: got len %0d want <=24", i, log_len[i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    int eoi_cnt;
    apply_reset();
    for (int i = 0; i < 4; i++) push(0, 4, 'hC, 1'b1);
    run(2, -1, 0, 7);
    n_tests++;
    if (bus.lane_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL rst_mid_in_cb: got ready %b want 010", bus.lane_ready);
    end
    eoi_cnt = 0;
    foreach (log_eoi[i]) if (log_eoi[i]) eoi_cnt++;
    push(1, 4, 'hD, 1'b1);
    drive_lanes();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if ({bus.out_valid, bus.out_eoi, busy, done, err, bus.lane_ready} !== 8'b0 ||
        {bus.out_len, bus.out_bin} !== 30'd0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got v%b e%b b%b d%b r%b rdy%b len %0d bin %h want all 0",
               bus.out_valid, bus.out_eoi, busy, done, err, bus.lane_ready, bus.out_len, bus.out_bin);
    end
    n_tests++;
    if (eoi_cnt != 0) begin
      n_fail++;
      $display("FAIL rst_mid_eoi: got %0d eoi want 0", eoi_cnt);
    end
    cb_q.delete();
    for (int i = 0; i < 8; i++) push(0, 4, 'h10 + i, 1'b1);
    for (int i = 0; i < 2; i++) push(1, 4, 'h20 + i, 1'b1);
    for (int i = 0; i < 2; i++) push(2, 4, 'h30 + i, 1'b1);
    run(2, -1, 0, 60);
    n_tests++;
    if (log_len.size() != 12 || done_cyc < 0) begin
      n_fail++;
      $display("FAIL rst_mid_rerun: got %0d codes done_cyc %0d want 12 >=0", log_len.size(), done_cyc);
    end else begin
      n_tests++;
      if (log_eoi[11] !== 1'b1 || log_eoi[5] !== 1'b0 || log_bin[5] !== 24'h30) begin
        n_fail++;
        $display("FAIL rst_mid_eoi_pos: got eoi5 %b eoi11 %b bin5 %h want 0 1 000030",
                 log_eoi[5], log_eoi[11], log_bin[5]);
      end
    end
  endtask

  task automatic test_start_ignored();
    apply_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) push(0, 2, 'h40 + i, 1'b1);
      push(1, 2, 'h50, 1'b1);
      push(2, 2, 'h60, 1'b1);
    end
    run(2, 9, 1, 60);
    n_tests++;
    if (log_len.size() != 12 || done_cyc < 0) begin
      n_fail++;
      $display("FAIL restart_count: got %0d codes done_cyc %0d want 12 >=0", log_len.size(), done_cyc);
    end else begin
      n_tests++;
      if (log_eoi[11] !== 1'b1 || log_eoi[5] !== 1'b0) begin
        n_fail++;
        $display("FAIL restart_eoi: got eoi5 %b eoi11 %b want 0 1", log_eoi[5], log_eoi[11]);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_basic_mcu();
    test_back_to_back();
    test_zero_total();
    test_err_len();
    test_rst_mid();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conc_sched.md
CONC_SCHED -- requirements
Module: conc_sched

Interface
REQ-001 SHALL have parameter Y_BLKS, default 4, luma blocks per MCU (1..4).
REQ-002 SHALL have parameter CNT_W, default 16, width of the MCU counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  pulse; begins an image when idle.
REQ-006 SHALL have port mcu_total  input  CNT_W  MCUs in the image; sampled on an accepted start.
REQ-007 SHALL have port lane_len  input  18  code lengths, 6 bits per lane; lane 0=Y, 1=Cb, 2=Cr.
REQ-008 SHALL have port lane_bin  input  72  codes, 24 bits per lane, right-aligned.
REQ-009 SHALL have port lane_eob  input  3  per lane: this code is the last code of its block.
REQ-010 SHALL have port lane_valid  input  3  per lane: code offered.
REQ-011 SHALL have port lane_ready  output  3  per lane: code accepted when valid&ready.
REQ-012 SHALL have port out_len  output  6  code length to the byte concatenator.
REQ-013 SHALL have port out_bin  output  24  code to the byte concatenator, right-aligned.
REQ-014 SHALL have port out_valid  output  1  code valid to the concatenator.
REQ-015 SHALL have port out_eoi  output  1  end of image, coincident with the final code.
REQ-016 SHALL have port busy  output  1  image in progress, including flush.
REQ-017 SHALL have port done  output  1  one-cycle pulse when the image is complete.
REQ-018 SHALL have port err  output  1  sticky flag: a code with length > 24 was received.

Function
REQ-019 SHALL implement states IDLE, LUMA, CB, CR, FLUSH; reset state is IDLE.
REQ-020 SHALL, in IDLE, accept start: mcu_total != 0 -> LUMA, busy=1, block and MCU counters cleared; mcu_total == 0 -> pulse done next cycle and stay in IDLE.
REQ-021 SHALL ignore start in any state other than IDLE.
REQ-022 SHALL assert exactly one lane_ready bit: LUMA->bit0, CB->bit1, CR->bit2. All bits SHALL be 0 in IDLE and FLUSH. lane_ready SHALL be decoded from state only, with no dependence on lane_valid.
REQ-023 SHALL, on an accepted code, register out_len/out_bin from that lane and assert out_valid for one cycle in the next cycle (1-cycle latency, max one code per cycle).
REQ-024 SHALL hold out_len/out_bin when no transfer occurs; out_valid SHALL be 0 on cycles with no accepted code.
REQ-025 SHALL forward len 0 codes with out_valid=1 and out_len=0.
REQ-026 SHALL, for an accepted code with len > 24, set err and suppress out_valid for it; its eob SHALL still advance sequencing.
REQ-027 SHALL, in LUMA, count accepted eob codes; the Y_BLKS-th eob -> CB and the block count SHALL clear.
REQ-028 SHALL transition CB -> CR on an accepted Cb eob.
REQ-029 SHALL, on an accepted Cr eob, increment the MCU count; if the new count == mcu_total -> FLUSH, else -> LUMA.
REQ-030 SHALL assert out_eoi together with out_valid for the final Cr eob code only; out_eoi SHALL be 0 otherwise.
REQ-031 SHALL hold FLUSH for exactly 2 cycles, to cover the concatenator's EOI flush words.
REQ-032 SHALL, after FLUSH, pulse done=1 for one cycle with busy=0 in that cycle, and enter IDLE.
REQ-033 SHALL ignore lane_valid on non-selected lanes; codes on those lanes are neither consumed nor forwarded.
REQ-034 SHALL compare the MCU counter at full CNT_W width; mcu_total = 2^CNT_W-1 SHALL complete without wrap.

Reset
REQ-035 SHALL, while rst=1 at a clock edge, return to IDLE and clear out_len, out_bin, out_valid, out_eoi, busy, done, err, lane_ready and all counters to 0.
REQ-036 SHALL abandon an image on rst mid-image; a new start is needed, with no partial out_eoi.

Verification
REQ-037 SHALL test Y_BLKS=4, mcu_total=1, one code per block (len 4, bin 0xA, eob=1), all lanes valid -> 6 out_valid in order Y,Y,Y,Y,Cb,Cr, out_eoi on the 6th only, done 2 cycles after that out_valid.
REQ-038 SHALL test Cb and Cr valid from cycle 0 while Y supplies 3 codes per block -> lane_ready[2:1]=0 until the 4th Y eob is accepted; 12 Y codes precede the Cb code.
REQ-039 SHALL test a Y code with len 25, eob=1 -> err=1 and sticky, no out_valid for it, block count advances.
REQ-040 SHALL test start with mcu_total=0 -> done=1 next cycle, no out_valid, busy stays 0.
REQ-041 SHALL test rst asserted in CB state -> next cycle all outputs 0, state IDLE; start with mcu_total=2 then completes 12 codes normally.
REQ-042 SHALL test start pulsed again during LUMA -> ignored; the MCU count and mcu_total stay unchanged.
